timer_countdown_bcd: RTL
========================

# timer_countdown_bcd

Countdown timer core that produces the timer digits and the alarm flag consumed by `Clock_screen_top` (`digit0/1_HH_T`, `digit0/1_MM_T`, `digit0/1_SS_T`, `estado_alarma`). It loads an HH:MM:SS value in BCD from the configuration logic and counts down once per second. On reaching 00:00:00 it raises the ring flag until the flag is acknowledged or a ring timeout expires. All outputs are registered in the `clock` domain.

## Interface
- `TICK_COUNT`, 100_000_000, clock cycles per second (100 MHz board clock).
- `RING_SECONDS`, 30, seconds the ring flag stays asserted without acknowledgement.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `load`  in  1  one-cycle pulse; capture `load_hh/mm/ss`.
- `load_hh`  in  8  BCD hours {tens, units}; valid range 00–23.
- `load_mm`  in  8  BCD minutes; valid range 00–59.
- `load_ss`  in  8  BCD seconds; valid range 00–59.
- `start`  in  1  one-cycle pulse; begin or resume the countdown.
- `stop`  in  1  one-cycle pulse; pause the countdown.
- `alarm_ack`  in  1  one-cycle pulse; silence the ring.
- `digit0_HH_T`, `digit1_HH_T`, `digit0_MM_T`, `digit1_MM_T`, `digit0_SS_T`, `digit1_SS_T`  out  4 each  current value; digit0 = units, digit1 = tens.
- `estado_alarma`  out  1  high while in RING.
- `running`  out  1  high while in RUN.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- States:
  - IDLE: reset state, or after ring ends.
  - RUN: counting down.
  - PAUSE: stopped with a nonzero value.
  - RING: value reached zero; `estado_alarma` is high.
- Command priority in any one cycle: `load` > `alarm_ack` > `stop` > `start`.
- `load`:
  - Accepted only in IDLE or PAUSE.
  - Rejected if any BCD nibble is >9 or the field is out of range. A rejected load leaves the digits unchanged and pulses `load_err`.
  - Accepted in PAUSE → goes to IDLE.
  - Ignored silently in RUN or RING.
- `start`:
  - IDLE/PAUSE → RUN, only if the value is ≠ 00:00:00. Otherwise ignored.
  - Clears the prescaler.
- `stop`: RUN → PAUSE. The prescaler is frozen, and a tick in the same cycle is discarded.
- Prescaler:
  - Counts 0..TICK_COUNT-1, only in RUN.
  - Tick is asserted when the count equals TICK_COUNT-1; the count then wraps to 0.
- Decrement on tick, in BCD:
  - SS units 0→9 with a borrow into the tens.
  - SS tens 0→5 with a borrow into MM.
  - MM borrows from HH the same way.
  - HH units 0→9 with a borrow into the tens.
- Zero detection: if the decrement produces 00:00:00, go to RING on the same edge.
- RING:
  - The prescaler keeps running and counts ring seconds.
  - `alarm_ack`, or RING_SECONDS ticks elapsed → IDLE.
  - Digits hold at 00:00:00.
- `load_err` is the only pulse output. All other outputs are level.

## Timing
- Reset values: all digits 0, `estado_alarma` 0, `running` 0, `load_err` 0; state IDLE; prescaler 0; ring counter 0.
- Load pulse at edge n → digits or `load_err` visible after edge n+1.
- `start` accepted at edge n → `running`=1 after n+1. The first decrement is visible TICK_COUNT edges after n+1.
- The decrement to zero and `estado_alarma`=1 appear on the same edge. `running` drops on that edge.
- `alarm_ack` at edge n → `estado_alarma`=0 after n+1.
- Timeout: `estado_alarma` falls RING_SECONDS×TICK_COUNT edges after it rose.
- Reset mid-RUN or mid-RING: immediate asynchronous return to reset values. The loaded value is lost.
- `start` and `stop` in the same cycle while in RUN → PAUSE. In PAUSE the same pair is a no-op (stop wins).

## Structure
- Package `timer_pkg`:
  - State encoding (IDLE, RUN, PAUSE, RING).
  - BCD limit constants (tens max 5 for MM/SS, 2 for HH with units max 3 when tens = 2).
  - Function `bcd_valid(value, max_tens, max_units_at_max_tens)`.
- Sub-module `bcd_down_2d`, instanced three times (SS, MM, HH):
  - Inputs: two-digit BCD value, `dec_in`, max tens digit.
  - Outputs: next value, `borrow_out`, `is_zero`.
  - Combinational. Registers live in the top.

## Test plan
Benches run with TICK_COUNT=4 and RING_SECONDS=3.
- Load 00:00:03, start → digits 02, 01, 00 at 4-cycle spacing. `estado_alarma`=1 with the 00 update; with no ack it drops 12 cycles later; final state IDLE.
- Load 01:00:00, start, one tick → 00:59:59 (all borrows propagate).
- Load 00:05:00, start, stop after 6 cycles → hold at 00:04:59 with `running`=0. Start again → next decrement 4 cycles after resume.
- Load 24:00:00 → `load_err` pulse, digits unchanged. Load 00:6A:00 → `load_err`. Start with 00:00:00 → stays IDLE.
- In RING, assert `alarm_ack` together with `start` → ack wins, IDLE, `estado_alarma`=0 next edge.
- Assert reset during RUN at 00:00:02 → all outputs 0 immediately. After release, start is ignored because the value is zero.

Source files
------------

// File: rtl/timer_countdown_bcd_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the BCD countdown timer:
//   - state_t           : controller state encoding (IDLE, RUN, PAUSE, RING)
//   - BCD limit constants for the HH, MM and SS fields
//   - bcd_valid()       : range check of a two-digit BCD field
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_RING  = 2'd3
    } state_t;

    // Largest legal value of a single BCD digit.
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    // Minutes and seconds: 00..59.
    localparam logic [3:0] SS_MAX_TENS          = 4'd5;
    localparam logic [3:0] MM_MAX_TENS          = 4'd5;
    localparam logic [3:0] MS_MAX_UNITS_AT_MAX  = 4'd9;

    // Hours: 00..23, so the units digit is capped at 3 once tens reaches 2.
    localparam logic [3:0] HH_MAX_TENS          = 4'd2;
    localparam logic [3:0] HH_MAX_UNITS_AT_MAX  = 4'd3;

    // True when both nibbles are decimal digits and the field lies within
    // 00 .. {max_tens, max_units_at_max_tens}.
    function automatic logic bcd_valid(
        input logic [7:0] value,
        input logic [3:0] max_tens,
        input logic [3:0] max_units_at_max_tens
    );
        logic [3:0] tens;
        logic [3:0] units;
        tens  = value[7:4];
        units = value[3:0];
        return (units <= BCD_DIGIT_MAX) &&
               (tens  <= max_tens) &&
               ((tens != max_tens) || (units <= max_units_at_max_tens));
    endfunction

endpackage

// File: rtl/timer_countdown_bcd_bcd_down_2d.sv
// -----------------------------------------------------------------------------
// bcd_down_2d
// Combinational two-digit BCD decrementer, one instance per time field.
// Ports:
//   value      in  8  current field {tens, units}
//   dec_in     in  1  decrement request (borrow from the field below)
//   max_tens   in  4  tens digit reloaded when the field wraps below 00
//   next_value out 8  field after the optional decrement
//   borrow_out out 1  field wrapped below 00 (borrow from the field above)
//   is_zero    out 1  next_value is 00
// -----------------------------------------------------------------------------
module bcd_down_2d
    import timer_pkg::*;
(
    input  logic [7:0] value,
    input  logic       dec_in,
    input  logic [3:0] max_tens,
    output logic [7:0] next_value,
    output logic       borrow_out,
    output logic       is_zero
);

    logic [3:0] tens_s;
    logic [3:0] units_s;
    logic [3:0] next_tens_s;
    logic [3:0] next_units_s;

    assign tens_s  = value[7:4];
    assign units_s = value[3:0];

    // Digit-wise borrow: units wrap 0->9, tens wrap 0->max_tens.
    always_comb begin
        next_tens_s  = tens_s;
        next_units_s = units_s;
        borrow_out   = 1'b0;
        if (dec_in) begin
            if (units_s == 4'd0) begin
                next_units_s = BCD_DIGIT_MAX;
                if (tens_s == 4'd0) begin
                    next_tens_s = max_tens;
                    borrow_out  = 1'b1;
                end else begin
                    next_tens_s = tens_s - 4'd1;
                end
            end else begin
                next_units_s = units_s - 4'd1;
            end
        end else begin
            next_units_s = units_s;
        end
    end

    assign next_value = {next_tens_s, next_units_s};
    assign is_zero    = (next_value == 8'h00);

endmodule

// File: rtl/timer_countdown_bcd.sv
// -----------------------------------------------------------------------------
// timer_countdown_bcd
// HH:MM:SS BCD countdown timer with ring flag for the clock screen.
// Parameters:
//   TICK_COUNT    clock cycles per second
//   RING_SECONDS  seconds the ring flag stays up without acknowledgement
// Ports:
//   clock, reset              clock; asynchronous active-high reset
//   load, load_hh/mm/ss       load pulse and BCD value to capture
//   start, stop, alarm_ack    command pulses (priority load > ack > stop > start)
//   digit0/1_HH/MM/SS_T       current value, digit0 = units, digit1 = tens
//   estado_alarma             high while ringing
//   running                   high while counting down
//   load_err                  one-cycle pulse on a rejected load
// -----------------------------------------------------------------------------
module timer_countdown_bcd
    import timer_pkg::*;
#(
    parameter int unsigned TICK_COUNT   = 100_000_000,
    parameter int unsigned RING_SECONDS = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       start,
    input  logic       stop,
    input  logic       alarm_ack,
    output logic [3:0] digit0_HH_T,
    output logic [3:0] digit1_HH_T,
    output logic [3:0] digit0_MM_T,
    output logic [3:0] digit1_MM_T,
    output logic [3:0] digit0_SS_T,
    output logic [3:0] digit1_SS_T,
    output logic       estado_alarma,
    output logic       running,
    output logic       load_err
);

    localparam int unsigned PRESC_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int unsigned RING_W  = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_COUNT - 1);
    localparam logic [RING_W-1:0]  RING_LAST  = RING_W'(RING_SECONDS - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [7:0]          hh_r;
    logic [7:0]          mm_r;
    logic [7:0]          ss_r;
    logic [7:0]          hh_next_s;
    logic [7:0]          mm_next_s;
    logic [7:0]          ss_next_s;
    logic [PRESC_W-1:0]  presc_r;
    logic [PRESC_W-1:0]  presc_next_s;
    logic [RING_W-1:0]   ring_cnt_r;
    logic [RING_W-1:0]   ring_cnt_next_s;
    logic                load_err_r;
    logic                load_err_next_s;
    logic                alarm_r;
    logic                alarm_next_s;
    logic                running_r;
    logic                running_next_s;

    logic                tick_s;
    logic                load_ok_s;
    logic                value_nonzero_s;
    logic [7:0]          ss_dec_s;
    logic [7:0]          mm_dec_s;
    logic [7:0]          hh_dec_s;
    logic                ss_borrow_s;
    logic                mm_borrow_s;
    logic                hh_borrow_s;
    logic                ss_zero_s;
    logic                mm_zero_s;
    logic                hh_zero_s;
    logic                dec_to_zero_s;

    assign tick_s          = (presc_r == PRESC_LAST);
    assign value_nonzero_s = ({hh_r, mm_r, ss_r} != 24'h000000);
    assign load_ok_s       = bcd_valid(load_hh, HH_MAX_TENS, HH_MAX_UNITS_AT_MAX) &&
                             bcd_valid(load_mm, MM_MAX_TENS, MS_MAX_UNITS_AT_MAX) &&
                             bcd_valid(load_ss, SS_MAX_TENS, MS_MAX_UNITS_AT_MAX);

    // Seconds always decrement by one; borrows ripple into MM and HH.
    bcd_down_2d u_dec_ss (
        .value      (ss_r),
        .dec_in     (1'b1),
        .max_tens   (SS_MAX_TENS),
        .next_value (ss_dec_s),
        .borrow_out (ss_borrow_s),
        .is_zero    (ss_zero_s)
    );

    bcd_down_2d u_dec_mm (
        .value      (mm_r),
        .dec_in     (ss_borrow_s),
        .max_tens   (MM_MAX_TENS),
        .next_value (mm_dec_s),
        .borrow_out (mm_borrow_s),
        .is_zero    (mm_zero_s)
    );

    bcd_down_2d u_dec_hh (
        .value      (hh_r),
        .dec_in     (mm_borrow_s),
        .max_tens   (HH_MAX_TENS),
        .next_value (hh_dec_s),
        .borrow_out (hh_borrow_s),
        .is_zero    (hh_zero_s)
    );

    // An underflow out of HH cannot occur from a nonzero value; if it ever
    // does, it is treated as reaching zero so the timer rings rather than
    // wrapping to a bogus time.
    assign dec_to_zero_s = (ss_zero_s && mm_zero_s && hh_zero_s) || hh_borrow_s;

    // State, time value and prescaler registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hh_r       <= 8'h00;
            mm_r       <= 8'h00;
            ss_r       <= 8'h00;
            presc_r    <= '0;
            ring_cnt_r <= '0;
        end else begin
            state_r    <= state_next_s;
            hh_r       <= hh_next_s;
            mm_r       <= mm_next_s;
            ss_r       <= ss_next_s;
            presc_r    <= presc_next_s;
            ring_cnt_r <= ring_cnt_next_s;
        end
    end

    // Next-state and datapath update, commands resolved by priority.
    always_comb begin
        state_next_s    = state_r;
        hh_next_s       = hh_r;
        mm_next_s       = mm_r;
        ss_next_s       = ss_r;
        presc_next_s    = presc_r;
        ring_cnt_next_s = ring_cnt_r;
        load_err_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    if (load_ok_s) begin
                        hh_next_s = load_hh;
                        mm_next_s = load_mm;
                        ss_next_s = load_ss;
                    end else begin
                        load_err_next_s = 1'b1;
                    end
                end else if (start && value_nonzero_s) begin
                    state_next_s = ST_RUN;
                    presc_next_s = '0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Stop freezes the prescaler and swallows a coincident tick.
                if (stop) begin
                    state_next_s = ST_PAUSE;
                end else if (tick_s) begin
                    presc_next_s = '0;
                    if (dec_to_zero_s) begin
                        state_next_s    = ST_RING;
                        hh_next_s       = 8'h00;
                        mm_next_s       = 8'h00;
                        ss_next_s       = 8'h00;
                        ring_cnt_next_s = '0;
                    end else begin
                        hh_next_s = hh_dec_s;
                        mm_next_s = mm_dec_s;
                        ss_next_s = ss_dec_s;
                    end
                end else begin
                    presc_next_s = presc_r + PRESC_W'(1);
                end
            end
            ST_PAUSE: begin
                if (load) begin
                    if (load_ok_s) begin
                        state_next_s = ST_IDLE;
                        hh_next_s    = load_hh;
                        mm_next_s    = load_mm;
                        ss_next_s    = load_ss;
                    end else begin
                        load_err_next_s = 1'b1;
                    end
                end else if (stop) begin
                    // Stop outranks start, so a stop+start pair stays paused.
                    state_next_s = ST_PAUSE;
                end else if (start && value_nonzero_s) begin
                    state_next_s = ST_RUN;
                    presc_next_s = '0;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_RING: begin
                // The prescaler keeps running here to time the ring seconds.
                if (alarm_ack) begin
                    state_next_s    = ST_IDLE;
                    presc_next_s    = '0;
                    ring_cnt_next_s = '0;
                end else if (tick_s) begin
                    presc_next_s = '0;
                    if (ring_cnt_r == RING_LAST) begin
                        state_next_s    = ST_IDLE;
                        ring_cnt_next_s = '0;
                    end else begin
                        ring_cnt_next_s = ring_cnt_r + RING_W'(1);
                    end
                end else begin
                    presc_next_s = presc_r + PRESC_W'(1);
                end
            end
            default: begin
                state_next_s    = ST_IDLE;
                hh_next_s       = 8'h00;
                mm_next_s       = 8'h00;
                ss_next_s       = 8'h00;
                presc_next_s    = '0;
                ring_cnt_next_s = '0;
            end
        endcase
    end

    // Level outputs decoded from the state being entered.
    always_comb begin
        running_next_s = 1'b0;
        alarm_next_s   = 1'b0;
        case (state_next_s)
            ST_RUN:  running_next_s = 1'b1;
            ST_RING: alarm_next_s   = 1'b1;
            default: begin
                running_next_s = 1'b0;
                alarm_next_s   = 1'b0;
            end
        endcase
    end

    // Status output registers, aligned with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            running_r  <= 1'b0;
            alarm_r    <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            running_r  <= running_next_s;
            alarm_r    <= alarm_next_s;
            load_err_r <= load_err_next_s;
        end
    end

    assign digit0_HH_T   = hh_r[3:0];
    assign digit1_HH_T   = hh_r[7:4];
    assign digit0_MM_T   = mm_r[3:0];
    assign digit1_MM_T   = mm_r[7:4];
    assign digit0_SS_T   = ss_r[3:0];
    assign digit1_SS_T   = ss_r[7:4];
    assign estado_alarma = alarm_r;
    assign running       = running_r;
    assign load_err      = load_err_r;

endmodule
